relu_maxpool2x2: RTL and testbench
==================================

Name: relu_maxpool2x2

Overview:
- Downstream stage of the 25-tap convolution MAC. Consumes its signed 2*DATA_BW-bit window sums in raster order, one per valid cycle.
- Applies ReLU, arithmetic right shift and saturation to DATA_BW bits, then 2x2 stride-2 max pooling using a half-width line buffer.
- Emits one pooled DATA_BW-bit value per 2x2 block, plus an end-of-frame pulse.

Parameters:
- DATA_BW, 8, output width; input width is 2*DATA_BW.
- FMAP_W, 24, convolution output width in pixels; must be even and >= 2.
- FMAP_H, 24, convolution output height in rows; must be even and >= 2.
- SHIFT, 0, arithmetic right-shift amount applied after ReLU (0..2*DATA_BW-1).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- CLR  in  1  synchronous clear: aborts the current frame and resets all counters.
- IN_VALID  in  1  IN_DATA is valid this cycle; no backpressure.
- IN_DATA  in  2*DATA_BW  signed convolution sum, raster order.
- OUT_VALID  out  1  OUT_DATA is valid this cycle (single-cycle pulse).
- OUT_DATA  out  DATA_BW  pooled value; always in 0..2^(DATA_BW-1)-1.
- FRAME_DONE  out  1  one-cycle pulse coincident with the last OUT_VALID of a frame.

Behaviour:
- Reset (RST=1, async): col=0, row=0, hmax=0, line buffer contents are don't-care, OUT_VALID=0, OUT_DATA=0, FRAME_DONE=0.
- Quantize (combinational on IN_DATA):
  - r = (IN_DATA<0) ? 0 : IN_DATA.
  - q = r >>> SHIFT.
  - q saturates to 2^(DATA_BW-1)-1 if it exceeds that value; otherwise q.
  - Pooling operates on q, unsigned compare. Order is legal because ReLU, shift and saturation are all monotone.
- Counters:
  - col runs 0..FMAP_W-1 and row runs 0..FMAP_H-1; both advance only on IN_VALID.
  - col wraps to 0 at FMAP_W-1 and row increments.
  - row wraps to 0 after (FMAP_H-1, FMAP_W-1).
- Phases (state = {row[0], col[0]}):
  - EVEN_ROW/EVEN_COL: hmax <= q.
  - EVEN_ROW/ODD_COL: linebuf[col>>1] <= max(hmax, q).
  - ODD_ROW/EVEN_COL: hmax <= q.
  - ODD_ROW/ODD_COL: OUT_DATA <= max(hmax, q, linebuf[col>>1]); OUT_VALID <= 1.
- Line buffer: FMAP_W/2 entries of DATA_BW bits; single write or read per cycle; read combinational or registered, provided the latency rule below holds.
- Latency: OUT_VALID asserts the cycle after the input sample at (odd row, odd col) is accepted. Exactly (FMAP_W/2)*(FMAP_H/2) outputs per frame.
- OUT_VALID is low in every other cycle. OUT_DATA holds its last value when OUT_VALID=0.
- FRAME_DONE asserts with the output produced from sample (FMAP_H-1, FMAP_W-1). The next frame starts at row 0, col 0 with no idle cycle required.
- Stall: IN_VALID=0 freezes col, row, hmax and the line buffer. Gaps of any length between samples do not change results.
- CLR has priority over IN_VALID:
  - Next cycle col=0, row=0, OUT_VALID=0, FRAME_DONE=0; the sample presented in the CLR cycle is discarded.
  - An output already registered from the previous cycle is still presented for its one cycle.
- RST asserted mid-frame takes effect immediately, regardless of CLK; the partial frame is lost.
- Width rule: all comparisons on DATA_BW-bit unsigned values; no overflow is possible.

Test Plan:
- Reset / idle: RST=1 then release, no IN_VALID for 20 cycles -> OUT_VALID=0, FRAME_DONE=0, OUT_DATA=0 throughout.
- Basic pool (FMAP_W=4, FMAP_H=4, SHIFT=0): feed 1..16 back-to-back -> 4 outputs 6, 8, 14, 16. Each output appears one cycle after inputs 6, 8, 14, 16 respectively; FRAME_DONE with 16.
- ReLU/saturation (FMAP_W=2, FMAP_H=2, SHIFT=0):
  - Inputs -5, -300, -1, -7 -> output 0.
  - Inputs 10, 200, -3, 50 -> output 127.
  - With SHIFT=2, inputs 40, 13, 0, -8 -> output 10.
- Stalls: repeat the basic-pool case with random IN_VALID gaps of 0-5 cycles -> identical 4 values and FRAME_DONE timing relative to the last input.
- Back-to-back frames: two 4x4 frames (1..16, then 16..1 descending) with no gap -> outputs 6, 8, 14, 16 then 16, 14, 8, 6; two FRAME_DONE pulses.
- Mid-frame abort: CLR after 7 inputs of frame 1..16, then a full frame of 1..16 -> only 4 outputs (6, 8, 14, 16) after the CLR. Repeat using RST instead of CLR for the same result.

Source files
------------

// File: rtl/relu_maxpool2x2.sv
// rtl/relu_maxpool2x2.sv - ReLU, shift and saturate convolution sums, then 2x2 stride-2 max pool
module relu_maxpool2x2 #(
  parameter int DATA_BW = 8,
  parameter int FMAP_W  = 24,
  parameter int FMAP_H  = 24,
  parameter int SHIFT   = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CLR,
  input  logic                   IN_VALID,
  input  logic [2*DATA_BW-1:0]   IN_DATA,
  output logic                   OUT_VALID,
  output logic [DATA_BW-1:0]     OUT_DATA,
  output logic                   FRAME_DONE
);

  localparam int IN_BW    = 2 * DATA_BW;
  localparam int COL_W    = $clog2(FMAP_W);
  localparam int ROW_W    = $clog2(FMAP_H);
  localparam int LB_DEPTH = FMAP_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [IN_BW-1:0] SAT_MAX  = IN_BW'((1 << (DATA_BW - 1)) - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FMAP_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FMAP_H - 1);

  // Phase is {row[0], col[0]} of the sample being accepted
  localparam logic [1:0] PH_EVEN_EVEN = 2'b00;
  localparam logic [1:0] PH_EVEN_ODD  = 2'b01;
  localparam logic [1:0] PH_ODD_EVEN  = 2'b10;
  localparam logic [1:0] PH_ODD_ODD   = 2'b11;

  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DATA_BW-1:0] hmax_q, hmax_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_BW-1:0] out_data_q, out_data_d;
  logic               frame_done_q, frame_done_d;

  logic [IN_BW-1:0]   relu_val;
  logic [IN_BW-1:0]   shifted_val;
  logic [DATA_BW-1:0] q_val;
  logic [DATA_BW-1:0] pair_max;
  logic [DATA_BW-1:0] pool_max;
  logic [DATA_BW-1:0] lb_rdata;
  logic [LB_AW-1:0]   lb_addr;
  logic               lb_we;

  logic [DATA_BW-1:0] linebuf_mem [LB_DEPTH];

  // Clamping negatives first keeps the shift logical and the result monotone
  always_comb begin
    relu_val    = IN_DATA[IN_BW-1] ? '0 : IN_DATA;
    shifted_val = relu_val >> SHIFT;
    q_val       = (shifted_val > SAT_MAX) ? SAT_MAX[DATA_BW-1:0] : shifted_val[DATA_BW-1:0];
  end

  always_comb begin
    lb_addr  = LB_AW'(col_q >> 1);
    lb_rdata = linebuf_mem[lb_addr];
    pair_max = (q_val > hmax_q) ? q_val : hmax_q;
    pool_max = (lb_rdata > pair_max) ? lb_rdata : pair_max;
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hmax_d       = hmax_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    if (CLR) begin
      col_d = '0;
      row_d = '0;
    end else if (IN_VALID) begin
      case ({row_q[0], col_q[0]})
        PH_EVEN_EVEN: hmax_d = q_val;
        PH_EVEN_ODD:  lb_we  = 1'b1;
        PH_ODD_EVEN:  hmax_d = q_val;
        PH_ODD_ODD: begin
          out_data_d   = pool_max;
          out_valid_d  = 1'b1;
          frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end
        default: hmax_d = hmax_q;
      endcase
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      col_q        <= '0;
      row_q        <= '0;
      hmax_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hmax_q       <= hmax_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer contents are don't-care after reset, so it carries no reset
  always_ff @(posedge CLK) begin
    if (lb_we) begin
      linebuf_mem[lb_addr] <= pair_max;
    end
  end

  assign OUT_VALID  = out_valid_q;
  assign OUT_DATA   = out_data_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// tb/tb_relu_maxpool2x2.sv - directed scoreboard bench for relu_maxpool2x2
module tb_relu_maxpool2x2;

  typedef struct {
    int data;
    int done;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_clr = 1'b0, zero_clr = 1'b0;
  logic        a_iv = 1'b0, b_iv = 1'b0, c_iv = 1'b0;
  logic [15:0] a_id = '0, b_id = '0, c_id = '0;
  logic        a_ov, b_ov, c_ov;
  logic [7:0]  a_od, b_od, c_od;
  logic        a_fd, b_fd, c_fd;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  relu_maxpool2x2 #(.DATA_BW(8), .FMAP_W(4), .FMAP_H(4), .SHIFT(0)) dut_a (
    .CLK(clk), .RST(rst), .CLR(a_clr), .IN_VALID(a_iv), .IN_DATA(a_id),
    .OUT_VALID(a_ov), .OUT_DATA(a_od), .FRAME_DONE(a_fd));
  relu_maxpool2x2 #(.DATA_BW(8), .FMAP_W(2), .FMAP_H(2), .SHIFT(0)) dut_b (
    .CLK(clk), .RST(rst), .CLR(zero_clr), .IN_VALID(b_iv), .IN_DATA(b_id),
    .OUT_VALID(b_ov), .OUT_DATA(b_od), .FRAME_DONE(b_fd));
  relu_maxpool2x2 #(.DATA_BW(8), .FMAP_W(2), .FMAP_H(2), .SHIFT(2)) dut_c (
    .CLK(clk), .RST(rst), .CLR(zero_clr), .IN_VALID(c_iv), .IN_DATA(c_id),
    .OUT_VALID(c_ov), .OUT_DATA(c_od), .FRAME_DONE(c_fd));

  task automatic cmp(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each monitor pops the next expectation when its DUT produces output
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0 && q_a[0].cyc < cyc) begin
      cmp("a_missing_out", cyc, q_a[0].cyc);
      void'(q_a.pop_front());
    end
    if (a_ov) begin
      if (q_a.size() == 0) cmp("a_unexpected_out", int'(a_ov), 0);
      else begin
        e = q_a.pop_front();
        cmp("a_data", int'(a_od), e.data);
        cmp("a_done", int'(a_fd), e.done);
        cmp("a_cycle", cyc, e.cyc);
      end
    end else if (a_fd) cmp("a_stray_done", int'(a_fd), 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q_b.size() > 0 && q_b[0].cyc < cyc) begin
      cmp("b_missing_out", cyc, q_b[0].cyc);
      void'(q_b.pop_front());
    end
    if (b_ov) begin
      if (q_b.size() == 0) cmp("b_unexpected_out", int'(b_ov), 0);
      else begin
        e = q_b.pop_front();
        cmp("b_data", int'(b_od), e.data);
        cmp("b_done", int'(b_fd), e.done);
        cmp("b_cycle", cyc, e.cyc);
      end
    end else if (b_fd) cmp("b_stray_done", int'(b_fd), 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q_c.size() > 0 && q_c[0].cyc < cyc) begin
      cmp("c_missing_out", cyc, q_c[0].cyc);
      void'(q_c.pop_front());
    end
    if (c_ov) begin
      if (q_c.size() == 0) cmp("c_unexpected_out", int'(c_ov), 0);
      else begin
        e = q_c.pop_front();
        cmp("c_data", int'(c_od), e.data);
        cmp("c_done", int'(c_fd), e.done);
        cmp("c_cycle", cyc, e.cyc);
      end
    end else if (c_fd) cmp("c_stray_done", int'(c_fd), 0);
  end

  // Called just after a rising edge; the sample is accepted at the next edge
  task automatic send_a(input int d, input bit has_out, input int exp, input bit done);
    a_iv = 1'b1;
    a_id = 16'(d);
    if (has_out) q_a.push_back('{exp, int'(done), cyc + 1});
    @(posedge clk); #1;
    a_iv = 1'b0;
  endtask

  task automatic send_b(input int d, input bit has_out, input int exp);
    b_iv = 1'b1;
    b_id = 16'(d);
    if (has_out) q_b.push_back('{exp, 1, cyc + 1});
    @(posedge clk); #1;
    b_iv = 1'b0;
  endtask

  task automatic send_c(input int d, input bit has_out, input int exp);
    c_iv = 1'b1;
    c_id = 16'(d);
    if (has_out) q_c.push_back('{exp, 1, cyc + 1});
    @(posedge clk); #1;
    c_iv = 1'b0;
  endtask

  // Feeds the first n samples of a 4x4 frame; outputs expected after odd/odd samples
  task automatic frame_a(input int vals[16], input int outs[4], input int gap_max, input int n);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      bit pooled = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
      int g = $urandom_range(0, gap_max);
      send_a(vals[i], pooled, pooled ? outs[k] : 0, i == 15);
      if (pooled) k++;
      repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  int up[16];
  int down[16];
  int o_up[4] = '{6, 8, 14, 16};
  int o_dn[4] = '{16, 14, 8, 6};

  initial begin
    for (int i = 0; i < 16; i++) begin
      up[i]   = i + 1;
      down[i] = 16 - i;
    end

    repeat (2) @(posedge clk);
    #1;
    cmp("rst_out_valid", int'(a_ov), 0);
    cmp("rst_out_data", int'(a_od), 0);
    cmp("rst_frame_done", int'(a_fd), 0);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      cmp("idle_out_valid", int'(a_ov), 0);
      cmp("idle_frame_done", int'(a_fd), 0);
      cmp("idle_out_data", int'(a_od), 0);
    end
    @(posedge clk); #1;

    frame_a(up, o_up, 0, 16);
    drain();

    send_b(-5, 0, 0); send_b(-300, 0, 0); send_b(-1, 0, 0); send_b(-7, 1, 0);
    send_b(10, 0, 0); send_b(200, 0, 0); send_b(-3, 0, 0); send_b(50, 1, 127);
    send_c(40, 0, 0); send_c(13, 0, 0); send_c(0, 0, 0); send_c(-8, 1, 10);
    send_b(32767, 0, 0); send_b(127, 0, 0); send_b(0, 0, 0); send_b(126, 1, 127);
    drain();

    frame_a(up, o_up, 5, 16);
    drain();

    frame_a(up, o_up, 0, 16);
    frame_a(down, o_dn, 0, 16);
    drain();

    frame_a(up, o_up, 0, 7);
    a_clr = 1'b1;
    a_iv  = 1'b1;
    a_id  = 16'd99;
    @(posedge clk); #1;
    a_clr = 1'b0;
    a_iv  = 1'b0;
    frame_a(up, o_up, 0, 16);
    drain();

    frame_a(up, o_up, 0, 7);
    #2;
    rst = 1'b1;
    #1;
    cmp("async_rst_out_valid", int'(a_ov), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    frame_a(up, o_up, 0, 16);
    drain();

    cmp("a_queue_empty", q_a.size(), 0);
    cmp("b_queue_empty", q_b.size(), 0);
    cmp("c_queue_empty", q_c.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
